bin2bcd_seq: RTL
================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL provide parameter: BIN_W, default 10, binary input width; supported range 4..13, always four BCD digits out.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  conversion request, sampled on rising edge of clk.
REQ-005 SHALL have port: bin  input  BIN_W  unsigned binary operand, sampled only on the accepting edge.
REQ-006 SHALL have port: bcd3  output  4  thousands digit.
REQ-007 SHALL have port: bcd2  output  4  hundreds digit.
REQ-008 SHALL have port: bcd1  output  4  tens digit.
REQ-009 SHALL have port: bcd0  output  4  units digit.
REQ-010 SHALL have port: ready  output  1  high when idle and able to accept start.
REQ-011 SHALL have port: done_tick  output  1  one-cycle pulse marking a new valid result.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, OP, DONE.
REQ-013 SHALL drive ready=1 only in IDLE; done_tick=1 only in DONE.
REQ-014 SHALL, on an edge in IDLE with start=1, capture bin into a BIN_W shift register, clear the 16-bit working BCD register, load the iteration counter with BIN_W, and enter OP.
REQ-015 SHALL, in IDLE with start=0, hold state and all outputs.
REQ-016 SHALL, on each edge in OP, first add 3 to every working digit >=5, then shift {working BCD, shift register} left by one bit, then decrement the counter (double dabble).
REQ-017 SHALL leave OP for DONE on the edge performing the BIN_W-th shift; OP lasts exactly BIN_W cycles.
REQ-018 SHALL update bcd3..bcd0 from the final working register on the OP->DONE edge; DONE lasts exactly one cycle, then IDLE.
REQ-019 SHALL give fixed latency: start accepted at edge E0, done_tick high in the cycle after edge E0+BIN_W, ready high again after edge E0+BIN_W+1.
REQ-020 SHALL ignore start in OP and DONE; no queuing, no abort, captured operand unaffected by later bin changes.
REQ-021 SHALL hold bcd3..bcd0 stable from one DONE until the next OP->DONE edge.
REQ-022 SHALL accept a start in the first IDLE cycle after DONE (back-to-back throughput one conversion per BIN_W+2 cycles).
REQ-023 SHALL produce every digit in 0..9; for BIN_W=10 the maximum input 1023 SHALL give 1,0,2,3.
REQ-024 SHALL give all-zero digits for bin=0 with normal latency and a done_tick.

Reset
REQ-025 SHALL, on any edge with reset=1, enter IDLE, clear bcd3..bcd0, working register, shift register and counter; ready=1 and done_tick=0 from the following cycle.
REQ-026 SHALL give reset priority over start on the same edge.
REQ-027 SHALL abandon an in-progress conversion on reset mid-OP or in DONE with no done_tick for it.

Structure
REQ-028 SHALL place the state encoding (IDLE/OP/DONE), the digit count (4), and the add-3 threshold (5) in a shared package.
REQ-029 SHALL use one sub-module, bcd_digit_adj: combinational 4-bit add-3-if->=5, instantiated four times.
REQ-030 SHALL keep all state in clk-domain registers; no latches, no derived clocks.

Verification
REQ-031 SHALL test: reset, then bin=131, start for one cycle -> done_tick 11 cycles after acceptance; digits 0,1,3,1.
REQ-032 SHALL test: bin=1023 -> digits 1,0,2,3; bin=0 -> digits 0,0,0,0, each with exactly one done_tick.
REQ-033 SHALL test: start held high continuously with bin=999 -> conversions every 12 cycles, each yielding 0,9,9,9.
REQ-034 SHALL test: start at E0 with bin=500, change bin to 7 and pulse start during OP -> result 0,5,0,0; second start ignored.
REQ-035 SHALL test: reset asserted 4 cycles into OP -> no done_tick, digits 0, ready=1 next cycle; fresh start bin=42 -> 0,0,4,2.
REQ-036 SHALL test: exhaustive sweep 0..1023 against a reference model -> all digits match, latency constant.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// FSM state encoding, digit count and the double-dabble add-3 threshold.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          NUM_DIGITS = 4;
    localparam int          BCD_W      = 4 * NUM_DIGITS;
    localparam logic [3:0]  ADJ_THRESH = 4'd5;

endpackage : bin2bcd_seq_pkg

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Digits entering here are always 0..9, so the sum never exceeds 12.
    assign dout = (din >= ADJ_THRESH) ? (din + 4'd3) : din;

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: BIN_W-bit unsigned to four BCD digits.
// Latency: BIN_W cycles in OP plus one DONE cycle; done_tick after edge E0+BIN_W.
// Backpressure: start is only taken while ready is high, ignored otherwise.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W = 10
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0,
    output logic             ready,
    output logic             done_tick
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CAT_W = BCD_W + BIN_W;

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   sreg;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   work_adj;
    logic [CAT_W-1:0]   shf;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd_q;
    logic               last;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work[4*g +: 4]),
            .dout (work_adj[4*g +: 4])
        );
    end

    // Adjusted digits and the remaining operand bits shift as one register.
    assign shf  = {work_adj, sreg} << 1;
    assign last = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_OP;
            ST_OP:   if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg  <= '0;
            work  <= '0;
            cnt   <= '0;
            bcd_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg <= bin;
                        work <= '0;
                        cnt  <= CNT_W'(BIN_W);
                    end
                end
                ST_OP: begin
                    work <= shf[CAT_W-1:BIN_W];
                    sreg <= shf[BIN_W-1:0];
                    cnt  <= cnt - CNT_W'(1);
                    // The final shift's result goes straight to the output digits.
                    if (last) begin
                        bcd_q <= shf[CAT_W-1:BIN_W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready     = (state == ST_IDLE);
    assign done_tick = (state == ST_DONE);
    assign bcd3      = bcd_q[15:12];
    assign bcd2      = bcd_q[11:8];
    assign bcd1      = bcd_q[7:4];
    assign bcd0      = bcd_q[3:0];

endmodule : bin2bcd_seq
